// File: rtl/dsp_simd_add_scheduler_if.sv
// ---------------------------------------------------------------------------
// dsp_simd_add_scheduler_if
//
// Requester-side bundle of the SIMD adder scheduler: per-requester request
// handshake with operands, and the per-requester result strobe and data.
//
//   req_valid [NUM_REQ]         request valid, one bit per requester
//   req_ready [NUM_REQ]         request accepted this cycle
//   req_a/req_b [NUM_REQ*DATA_W] operands, slice i belongs to requester i
//   rsp_valid [NUM_REQ]         one-cycle result strobe per requester
//   rsp_data [NUM_REQ*DATA_W]   signed sum, slice i belongs to requester i
//
// Modports: master = requesters, slave = scheduler.
// ---------------------------------------------------------------------------
interface dsp_simd_add_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 24
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ*DATA_W-1:0] rsp_data;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/dsp_simd_add_scheduler.sv
// ---------------------------------------------------------------------------
// dsp_simd_add_scheduler
//
// Shares one two-lane signed SIMD adder (LATENCY clken-qualified cycles)
// between NUM_REQ requesters. Each RUN cycle a round-robin arbiter grants up
// to two requests, packs them into lanes 0/1, tracks the owners through a tag
// pipeline and registers each lane sum back into the owner's response slot.
// The adder's synchronous reset is sequenced at start-up and after a flush,
// and its clock enable is dropped whenever nothing is in flight.
//
// Ports:
//   clk, areset            clock, asynchronous active-high reset
//   req_if (slave)         requester handshake, operands and responses
//   flush / flush_done     drain in-flight ops and re-reset the adder / pulse
//   busy                   high unless in RUN with an empty tag pipeline
//   dsp_a0/b0/a1/b1        adder lane operands
//   dsp_clken, dsp_reset   adder clock enable and synchronous reset
//   dsp_add0/add1          adder lane sums
//
// Optional feature (macro DSP_SCHED_PERF_CNT_EN):
//   perf_ops         granted operations, saturating, cleared on flush_done
//   perf_idle_lanes  unused lane slots in RUN cycles with pending requests
// ---------------------------------------------------------------------------
module dsp_simd_add_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 2,
    parameter int DATA_W  = 24
) (
    input  logic                 clk,
    input  logic                 areset,
    dsp_simd_add_scheduler_if.slave req_if,
    input  logic                 flush,
    output logic                 flush_done,
    output logic                 busy,
    output logic [DATA_W-1:0]    dsp_a0,
    output logic [DATA_W-1:0]    dsp_b0,
    output logic [DATA_W-1:0]    dsp_a1,
    output logic [DATA_W-1:0]    dsp_b1,
    output logic                 dsp_clken,
    output logic                 dsp_reset,
    input  logic [DATA_W-1:0]    dsp_add0,
    input  logic [DATA_W-1:0]    dsp_add1
`ifdef DSP_SCHED_PERF_CNT_EN
    ,
    output logic [31:0]          perf_ops,
    output logic [31:0]          perf_idle_lanes
`endif
);

    localparam int IDW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(LATENCY + 2);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_DRAIN
    } state_e;

    typedef struct packed {
        logic           v0;
        logic [IDW-1:0] id0;
        logic           v1;
        logic [IDW-1:0] id1;
    } tag_t;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   init_cnt_q, init_cnt_d;
    logic               from_drain_q, from_drain_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    tag_t               tag_q [LATENCY];
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ*DATA_W-1:0] rsp_data_q;

    logic               grant_en;
    logic               grant0, grant1;
    logic [IDW-1:0]     id0, id1;
    logic [IDW-1:0]     last_id;
    logic [IDW-1:0]     idx_w;
    int                 idx;
    logic [NUM_REQ-1:0] ready_c;
    logic               pipe_busy;
    logic               init_last;
    logic [NUM_REQ-1:0] hit0, hit1;
    tag_t               tail;

    assign grant_en  = (state_q == ST_RUN) && !flush;
    assign init_last = (init_cnt_q == CNT_W'(LATENCY));
    assign tail      = tag_q[LATENCY-1];

    // Round-robin: scan cyclically from rr_ptr; the first valid requester
    // takes lane 0, the next one found takes lane 1.
    always_comb begin
        // NOTE: every variable gets a default before any condition so the
        // block stays purely combinational (no latch inferred).
        grant0 = 1'b0;
        grant1 = 1'b0;
        id0    = '0;
        id1    = '0;
        idx    = 0;
        idx_w  = '0;
        if (grant_en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                idx_w = IDW'(idx);
                if (req_if.req_valid[idx_w]) begin
                    if (!grant0) begin
                        grant0 = 1'b1;
                        id0    = idx_w;
                    end else if (!grant1) begin
                        grant1 = 1'b1;
                        id1    = idx_w;
                    end
                end
            end
        end
    end

    always_comb begin
        ready_c = '0;
        if (grant0) ready_c[id0] = 1'b1;
        if (grant1) ready_c[id1] = 1'b1;
    end

    assign req_if.req_ready = ready_c;

    // Unused lanes are driven to zero so idle lanes never toggle the adder.
    assign dsp_a0 = grant0 ? req_if.req_a[int'(id0)*DATA_W +: DATA_W] : '0;
    assign dsp_b0 = grant0 ? req_if.req_b[int'(id0)*DATA_W +: DATA_W] : '0;
    assign dsp_a1 = grant1 ? req_if.req_a[int'(id1)*DATA_W +: DATA_W] : '0;
    assign dsp_b1 = grant1 ? req_if.req_b[int'(id1)*DATA_W +: DATA_W] : '0;

    // Pointer moves past the last requester granted this cycle.
    always_comb begin
        last_id  = grant1 ? id1 : id0;
        rr_ptr_d = rr_ptr_q;
        if (grant0) begin
            rr_ptr_d = (int'(last_id) == NUM_REQ - 1) ? '0 : last_id + IDW'(1);
        end
    end

    always_comb begin
        pipe_busy = 1'b0;
        for (int s = 0; s < LATENCY; s++) begin
            pipe_busy = pipe_busy | tag_q[s].v0 | tag_q[s].v1;
        end
    end

    // Outputs are forced quiet while areset is held; dsp_reset stays high
    // because the state register sits in INIT.
    assign dsp_clken  = !areset && (grant0 || pipe_busy || (state_q == ST_INIT));
    assign dsp_reset  = (state_q == ST_INIT);
    assign busy       = !areset && ((state_q != ST_RUN) || pipe_busy);
    assign flush_done = (state_q == ST_INIT) && init_last && from_drain_q;

    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        from_drain_d = from_drain_q;
        unique case (state_q)
            ST_INIT: begin
                if (init_last) begin
                    state_d      = ST_RUN;
                    init_cnt_d   = '0;
                    from_drain_d = 1'b0;
                end else begin
                    init_cnt_d = init_cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (flush) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!pipe_busy) begin
                    state_d      = ST_INIT;
                    init_cnt_d   = '0;
                    from_drain_d = 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of its inputs.
        if (areset) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= '0;
            from_drain_q <= 1'b0;
            rr_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            from_drain_q <= from_drain_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    // Tag pipeline mirrors the adder: it only advances when the adder does.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            // NOTE: the tag pipe is reset explicitly (not left as plain
            // storage) so that ops in flight at reset never produce a response.
            for (int s = 0; s < LATENCY; s++) tag_q[s] <= '0;
        end else if (dsp_clken) begin
            tag_q[0] <= '{v0: grant0, id0: id0, v1: grant1, id1: id1};
            for (int s = 1; s < LATENCY; s++) tag_q[s] <= tag_q[s-1];
        end
    end

    // Lanes always carry distinct owners, so hit0 and hit1 never overlap.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            hit0[i] = dsp_clken && tail.v0 && (tail.id0 == IDW'(i));
            hit1[i] = dsp_clken && tail.v1 && (tail.id1 == IDW'(i));
        end
        rsp_valid_d = hit0 | hit1;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (hit0[i]) rsp_data_q[i*DATA_W +: DATA_W] <= dsp_add0;
                else if (hit1[i]) rsp_data_q[i*DATA_W +: DATA_W] <= dsp_add1;
            end
        end
    end

    assign req_if.rsp_valid = rsp_valid_q;
    assign req_if.rsp_data  = rsp_data_q;

`ifdef DSP_SCHED_PERF_CNT_EN
    logic [31:0] perf_ops_q, perf_ops_d;
    logic [31:0] perf_idle_q, perf_idle_d;
    logic [1:0]  n_grant;
    logic [32:0] ops_sum, idle_sum;

    always_comb begin
        n_grant     = 2'(grant0) + 2'(grant1);
        ops_sum     = 33'(perf_ops_q) + 33'(n_grant);
        idle_sum    = 33'(perf_idle_q) + 33'(2'd2 - n_grant);
        perf_ops_d  = ops_sum[32] ? '1 : ops_sum[31:0];
        perf_idle_d = perf_idle_q;
        if ((state_q == ST_RUN) && (|req_if.req_valid)) begin
            perf_idle_d = idle_sum[32] ? '1 : idle_sum[31:0];
        end
        if (flush_done) begin
            perf_ops_d  = '0;
            perf_idle_d = '0;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            perf_ops_q  <= '0;
            perf_idle_q <= '0;
        end else begin
            perf_ops_q  <= perf_ops_d;
            perf_idle_q <= perf_idle_d;
        end
    end

    assign perf_ops        = perf_ops_q;
    assign perf_idle_lanes = perf_idle_q;
`endif

endmodule
